// File: rtl/median_pkg.sv
// Shared types for the median datapath: sample type and window size.
// Used by the window feeder and by the downstream median/sort stages.
package median_pkg;

  typedef logic [31:0] data_t;

  // Number of taps in a median window.
  localparam int unsigned MEDIAN_N = 5;

  // Width of the window fill counter (counts 0..MEDIAN_N).
  localparam int unsigned FILL_W = 3;

endpackage

// File: rtl/median_window_feeder.sv
// Streaming front end for the 5-input median network.
// Collects samples into a 5-tap sliding window and presents it registered with
// valid/ready. Frames are delimited by in_last; window fill restarts per frame.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   sample handshake; in_data sample, in_last end of frame
//   win_valid/out_ready window handshake
//   data_0..data_4      window taps, oldest to newest
//   win_last            newest tap carried in_last
//   win_idx             index of the window within its frame
//   short_frame         1-cycle pulse: frame ended before a window was formed
module median_window_feeder
  import median_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              win_valid,
  input  logic              out_ready,
  output data_t             data_0,
  output data_t             data_1,
  output data_t             data_2,
  output data_t             data_3,
  output data_t             data_4,
  output logic              win_last,
  output logic [IDX_W-1:0]  win_idx,
  output logic              short_frame
);

  localparam logic [FILL_W-1:0] FillFull = FILL_W'(MEDIAN_N);

  data_t             tap_q [MEDIAN_N];
  data_t             tap_d [MEDIAN_N];
  logic [FILL_W-1:0] fill_q, fill_d, fill_nx;
  logic              win_valid_q, win_valid_d;
  logic              win_last_q, win_last_d;
  logic [IDX_W-1:0]  win_idx_q, win_idx_d;
  logic              short_q, short_d;
  logic              acc;

  // A held window blocks intake unless it is being consumed this cycle.
  assign in_ready = !win_valid_q || out_ready;
  assign acc      = in_valid && in_ready;
  assign fill_nx  = (fill_q >= FillFull) ? FillFull : fill_q + FILL_W'(1);

  always_comb begin
    tap_d       = tap_q;
    fill_d      = fill_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    win_idx_d   = win_idx_q;
    short_d     = 1'b0;
    if (acc) begin
      for (int i = 0; i < MEDIAN_N - 1; i++) begin
        tap_d[i] = tap_q[i+1];
      end
      tap_d[MEDIAN_N-1] = data_t'(in_data);
      // End of frame: next sample starts filling a fresh window.
      fill_d      = in_last ? '0 : fill_nx;
      win_valid_d = (fill_nx == FillFull);
      if (fill_nx == FillFull) begin
        win_last_d = in_last;
        // fill 4->5 is the frame's first window; saturated fill means a later one.
        win_idx_d  = (fill_q == FillFull) ? win_idx_q + IDX_W'(1) : '0;
      end
      short_d = in_last && (fill_nx != FillFull);
    end else if (out_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEDIAN_N; i++) begin
        tap_q[i] <= '0;
      end
      fill_q      <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_idx_q   <= '0;
      short_q     <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      fill_q      <= fill_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_idx_q   <= win_idx_d;
      short_q     <= short_d;
    end
  end

  assign data_0      = tap_q[0];
  assign data_1      = tap_q[1];
  assign data_2      = tap_q[2];
  assign data_3      = tap_q[3];
  assign data_4      = tap_q[4];
  assign win_valid   = win_valid_q;
  assign win_last    = win_last_q;
  assign win_idx     = win_idx_q;
  assign short_frame = short_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Scoreboard bench for median_window_feeder: the driver feeds a per-frame
// sample model that queues expected windows and short-frame pulses; a monitor
// pops and compares whenever the DUT hands over a window or pulses short_frame.
module tb_median_window_feeder;
  import median_pkg::*;

  typedef struct packed {
    logic [4:0][31:0] d;
    logic             last;
    logic [15:0]      idx;
  } win_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        win_valid;
  logic        out_ready = 1'b1;
  data_t       data_0, data_1, data_2, data_3, data_4;
  logic        win_last;
  logic [15:0] win_idx;
  logic        short_frame;

  int checks = 0;
  int errors = 0;
  int or_mode = 0;  // 0: out_ready high, 1: random, 2: low

  win_t  exp_q[$];
  int    short_q[$];
  data_t frm[$];
  int    frm_cnt = 0;
  int    frame_no = 0;

  median_window_feeder #(.DATA_W(32), .IDX_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .win_valid(win_valid),
    .out_ready(out_ready), .data_0(data_0), .data_1(data_1), .data_2(data_2),
    .data_3(data_3), .data_4(data_4), .win_last(win_last), .win_idx(win_idx),
    .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  always begin
    @(posedge clk);
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Reference model: a window is the last five samples of the current frame.
  function automatic void model_accept(input data_t d, input logic l);
    win_t w;
    frm.push_back(d);
    if (frm.size() > 5) void'(frm.pop_front());
    frm_cnt++;
    if (frm_cnt >= 5) begin
      for (int i = 0; i < 5; i++) w.d[i] = frm[i];
      w.last = l;
      w.idx  = 16'(frm_cnt - 5);
      exp_q.push_back(w);
    end
    if (l) begin
      if (frm_cnt < 5) short_q.push_back(frame_no);
      frm_cnt = 0;
      frm.delete();
      frame_no++;
    end
  endfunction

  function automatic win_t dut_win();
    win_t w;
    w.d[0] = data_0; w.d[1] = data_1; w.d[2] = data_2;
    w.d[3] = data_3; w.d[4] = data_4;
    w.last = win_last;
    w.idx  = win_idx;
    return w;
  endfunction

  // Monitor
  logic prev_stall = 1'b0;
  win_t prev_win;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (in_ready !== (!win_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready: got %b, want %b", in_ready, !win_valid || out_ready);
      end
      if (prev_stall) begin
        checks++;
        if (dut_win() !== prev_win || win_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_stable: got %h v=%b, want %h v=1", dut_win(), win_valid, prev_win);
        end
      end
      prev_stall = win_valid && !out_ready;
      prev_win   = dut_win();
      if (win_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL window: got unexpected %h, want none", dut_win());
        end else begin
          win_t e;
          e = exp_q.pop_front();
          if (dut_win() !== e) begin
            errors++;
            $display("FAIL window: got %h, want %h", dut_win(), e);
          end
        end
      end
      if (short_frame) begin
        checks++;
        if (short_q.size() == 0) begin
          errors++;
          $display("FAIL short_frame: got unexpected pulse, want none");
        end else begin
          void'(short_q.pop_front());
        end
      end
    end
  end

  task automatic send(input data_t d, input logic l);
    logic took = 1'b0;
    int   n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!took) begin
      @(negedge clk);
      if (in_ready) begin
        took = 1'b1;
        model_accept(d, l);
      end
      @(posedge clk);
      #1;
      n++;
      if (!took && n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want acceptance", n);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || short_q.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || short_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d windows %0d shorts pending, want 0 0",
               exp_q.size(), short_q.size());
    end
  endtask

  task automatic check_zero(input string name);
    logic [191:0] got;
    got = {data_0, data_1, data_2, data_3, data_4, win_valid, win_last, win_idx, short_frame,
           13'd0};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s: got %h, want all zero", name, got);
    end
  endtask

  initial begin
    win_t w1;
    // Reset state
    idle(3);
    check_zero("reset_state");
    rst = 1'b0;
    idle(2);

    // Test 1: single 5-sample frame
    for (int i = 1; i <= 5; i++) send(data_t'(i * 10), i == 5);
    @(negedge clk);
    w1 = dut_win();
    checks++;
    if (!win_valid || w1 !== {32'd50, 32'd40, 32'd30, 32'd20, 32'd10, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL t1_window: got v=%b %h, want v=1 10..50 last=1 idx=0", win_valid, w1);
    end
    wait_drain();

    // Test 2: continuous 7-sample frame
    for (int i = 1; i <= 7; i++) send(data_t'(i), i == 7);
    wait_drain();

    // Test 3: short frame then a full one
    for (int i = 5; i <= 7; i++) send(data_t'(i), i == 7);
    for (int i = 1; i <= 5; i++) send(data_t'(i), i == 5);
    wait_drain();

    // Test 4: stall with in_valid held high
    or_mode = 2;
    idle(1);
    for (int i = 1; i <= 5; i++) send(data_t'(100 + i), 1'b0);
    fork
      send(data_t'(106), 1'b1);
      begin
        repeat (4) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || win_valid !== 1'b1) begin
            errors++;
            $display("FAIL t4_stall: got in_ready=%b win_valid=%b, want 0 1", in_ready, win_valid);
          end
        end
        or_mode = 0;
      end
    join
    wait_drain();

    // Test 5: reset mid-frame
    for (int i = 1; i <= 3; i++) send(data_t'(200 + i), 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("t5_reset_assert");
    frm.delete();
    frm_cnt = 0;
    idle(2);
    rst = 1'b0;
    idle(1);
    for (int i = 9; i >= 5; i--) send(data_t'(i), i == 5);
    wait_drain();

    // Test 6: random frames, random gaps and backpressure
    or_mode = 1;
    for (int f = 0; f < 1000; f++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int s = 0; s < len; s++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send(data_t'($urandom), s == len - 1);
      end
    end
    or_mode = 0;
    wait_drain();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
